user_rom_arbiter: RTL and testbench
===================================

# user_rom_arbiter

Round-robin OBI arbiter that shares one user-domain OBI subordinate among `NumReq` OBI managers. The subordinate is typically the user ROM, which grants in the same cycle and responds one cycle later. The block sits between the user-domain crossbar ports and the subordinate. It picks one request per cycle, forwards it, records the winner in an in-order routing FIFO, and steers each response back to the manager that issued it.

## Interface
- `ObiCfg`, `obi_pkg::ObiDefaultConfig`: OBI configuration shared by all ports.
- `obi_req_t`, `logic`: OBI request struct.
- `obi_rsp_t`, `logic`: OBI response struct.
- `NumReq`, 2: number of managers, from 2 to 8.
- `MaxTxn`, 2: routing FIFO depth, i.e. the maximum number of outstanding transactions, at least 1.
- `clk_i`  in  1  clock. There is one clock.
- `rst_i`  in  1  reset. It is asynchronous and active-high.
- `mgr_req_i`  in  `NumReq` x `obi_req_t`  manager requests.
- `mgr_rsp_o`  out  `NumReq` x `obi_rsp_t`  manager responses.
- `sbr_req_o`  out  `obi_req_t`  request to the shared subordinate.
- `sbr_rsp_i`  in  `obi_rsp_t`  response from the shared subordinate.
- `busy_o`  out  1  at least one transaction is outstanding.
- `spurious_o`  out  1  one-cycle pulse when `rvalid` arrives while the FIFO is empty.

## Operation
- **Eligibility.**
  - Manager i is eligible when `mgr_req_i[i].req` = 1.
  - Arbitration is enabled only when the FIFO is not full, or when a pop occurs in the same cycle.
- **Round-robin pick.**
  - Priority pointer `ptr`, `$clog2(NumReq)` bits, resets to 0.
  - Winner = first eligible index scanning `ptr`, `ptr+1`, …, wrapping modulo `NumReq`.
- **Forwarding.**
  - `sbr_req_o` = winner's request (`req`, `a` fields) unchanged.
  - If there is no winner or arbitration is disabled: `sbr_req_o.req` = 0 and `a` = 0.
- **Grant.**
  - `mgr_rsp_o[winner].gnt` = `sbr_rsp_i.gnt`.
  - All other `gnt` = 0.
- **Handshake** (`sbr_req_o.req` and `sbr_rsp_i.gnt`):
  - push the winner index into the FIFO;
  - `ptr` <= winner+1, with modulo `NumReq` wrap;
  - otherwise `ptr` holds. A manager that holds `req` without a grant keeps its priority.
- **Response routing.**
  - On `sbr_rsp_i.rvalid` with the FIFO non-empty: pop the head.
  - `mgr_rsp_o[head].rvalid` = 1 and `mgr_rsp_o[head].r` = `sbr_rsp_i.r`.
  - All other managers see `rvalid` = 0 and `r` = 0.
- **Spurious response.** `rvalid` with the FIFO empty:
  - the response is dropped and no manager sees it;
  - `spurious_o` pulses for one cycle.
- **Simultaneous push and pop.**
  - Both take effect and the count is unchanged.
  - When full, a push is permitted only together with a pop.
- **Outputs.**
  - `busy_o` = (FIFO count != 0).
  - The FIFO count ranges 0..`MaxTxn` and must never overflow or underflow.
- **Reset.**
  - While `rst_i` = 1: `ptr` = 0, FIFO empty, every `gnt` and `rvalid` = 0, `sbr_req_o.req` = 0, `busy_o` = 0, `spurious_o` = 0.
  - Reset mid-transaction discards all pending routing entries.
  - After release, the first response is treated as spurious if the subordinate still delivers it.

## Timing
- Request path is purely combinational, `mgr_req_i` to `sbr_req_o`: zero added latency.
- Grant path is combinational, `sbr_rsp_i.gnt` to `mgr_rsp_o.gnt`.
  - The subordinate's `gnt` must not depend on `rvalid`.
- Response path is combinational from `sbr_rsp_i` through the registered FIFO head: zero added latency.
- Throughput:
  - with the ROM subordinate (gnt same cycle, `rvalid` next cycle) and `MaxTxn` >= 1, one transaction per cycle is sustained;
  - steady state is one push plus one pop per cycle.
- Registered state updates on the rising `clk_i` edge: `ptr`, FIFO storage, FIFO pointers, count, `spurious_o`.
- Managers must hold `a` stable from `req` until `gnt`, as OBI requires. The arbiter does not re-arbitrate a held-but-ungranted request away from its owner unless a higher-priority eligible manager is present.

## Test plan
- **Single manager.** Manager 0 reads addr 0x0; the ROM returns 0x6F6D6953 one cycle later.
  - `mgr_rsp_o[0]` shows `gnt` in cycle 0, then `rvalid` with rdata 0x6F6D6953 and the matching `rid` in cycle 1.
  - `mgr_rsp_o[1]` stays all-zero.
- **Contention, NumReq=2.** Both managers request continuously for 6 cycles after reset.
  - Grants alternate 0,1,0,1,0,1.
  - Each `rvalid` goes to the manager granted in the previous cycle.
  - `busy_o` is 1 from cycle 1 onward.
- **Full FIFO.** `MaxTxn`=2 with a subordinate stalling `rvalid` for 3 cycles while both managers request.
  - Exactly 2 grants are issued, then `sbr_req_o.req` = 0 until the first `rvalid`.
  - On that cycle a push and a pop occur together.
- **Wrap-around, NumReq=3.**
  - With `ptr`=2 and managers 0 and 1 requesting, manager 0 wins and `ptr` becomes 1.
  - Next cycle, with the same requests, manager 1 wins.
- **Spurious and reset.**
  - `rvalid` injected with the FIFO empty: `spurious_o` = 1 for one cycle and all manager `rvalid` = 0.
  - `rst_i` asserted with 2 outstanding: `busy_o` = 0 immediately, and `ptr` = 0 after release.

Source files
------------

// File: rtl/user_rom_arbiter.sv
// Round-robin OBI arbiter sharing one user-domain subordinate (typically the user ROM) among
// NumReq managers; an in-order routing FIFO steers each response back to its issuer.

package obi_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 1;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        AddrWidth: ObiAddrWidth,
        DataWidth: ObiDataWidth,
        IdWidth:   ObiIdWidth
    };

    typedef struct packed {
        logic [ObiAddrWidth-1:0]   addr;
        logic                      we;
        logic [ObiDataWidth/8-1:0] be;
        logic [ObiDataWidth-1:0]   wdata;
        logic [ObiIdWidth-1:0]     aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module user_rom_arbiter #(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned       NumReq    = 2,
    parameter int unsigned       MaxTxn    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  obi_req_t [NumReq-1:0] mgr_req_i,
    output obi_rsp_t [NumReq-1:0] mgr_rsp_o,
    output obi_req_t              sbr_req_o,
    input  obi_rsp_t              sbr_rsp_i,
    output logic                  busy_o,
    output logic                  spurious_o
);

    localparam int unsigned PtrW  = $clog2(NumReq);
    localparam int unsigned FptrW = (MaxTxn > 1) ? $clog2(MaxTxn) : 1;
    localparam int unsigned CntW  = $clog2(MaxTxn + 1);

    typedef logic [PtrW-1:0] idx_t;

    if (NumReq < 2 || NumReq > 8) begin : gen_bad_numreq
        $error("user_rom_arbiter: NumReq must be in 2..8");
    end
    if (MaxTxn < 1) begin : gen_bad_maxtxn
        $error("user_rom_arbiter: MaxTxn must be at least 1");
    end
    if ($bits(sbr_rsp_i.r.rdata) != ObiCfg.DataWidth) begin : gen_bad_cfg
        $error("user_rom_arbiter: response type does not match ObiCfg.DataWidth");
    end

    function automatic idx_t rr_idx(input idx_t base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NumReq) begin
            sum = sum - NumReq;
        end
        return idx_t'(sum);
    endfunction

    function automatic logic [FptrW-1:0] fifo_inc(input logic [FptrW-1:0] p);
        return (32'(p) == MaxTxn - 1) ? '0 : p + 1'b1;
    endfunction

    idx_t             ptr_q, ptr_d;
    idx_t             fifo_q [MaxTxn];
    logic [FptrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             spurious_q, spurious_d;

    logic fifo_empty, fifo_full, pop, push, arb_en, win_valid;
    idx_t win_idx, head;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CntW'(MaxTxn));
    assign head       = fifo_q[rd_q];

    // Outputs are gated by reset so nothing leaks to managers or the subordinate while it is held.
    assign pop    = !rst_i && sbr_rsp_i.rvalid && !fifo_empty;
    assign arb_en = !rst_i && (!fifo_full || pop);
    assign push   = sbr_req_o.req && sbr_rsp_i.gnt;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!win_valid && mgr_req_i[rr_idx(ptr_q, k)].req) begin
                win_valid = 1'b1;
                win_idx   = rr_idx(ptr_q, k);
            end
        end
    end

    always_comb begin
        sbr_req_o = '0;
        if (arb_en && win_valid) begin
            sbr_req_o = mgr_req_i[win_idx];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            mgr_rsp_o[i] = '0;
            if (sbr_req_o.req && win_idx == idx_t'(i)) begin
                mgr_rsp_o[i].gnt = sbr_rsp_i.gnt;
            end
            if (pop && head == idx_t'(i)) begin
                mgr_rsp_o[i].rvalid = 1'b1;
                mgr_rsp_o[i].r      = sbr_rsp_i.r;
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        spurious_d = sbr_rsp_i.rvalid && fifo_empty;
        if (push) begin
            ptr_d = rr_idx(win_idx, 1);
            wr_d  = fifo_inc(wr_q);
        end
        if (pop) begin
            rd_d = fifo_inc(rd_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            spurious_q <= spurious_d;
        end
    end

    // NOTE: routing storage is not reset; a slot is only read after it was written, guarded by cnt_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_q] <= win_idx;
        end
    end

    assign busy_o     = !fifo_empty;
    assign spurious_o = spurious_q;

endmodule

// File: tb/tb_user_rom_arbiter.sv
// Randomised bench for user_rom_arbiter: a queue-based reference model checks arbitration every
// cycle, and a separate monitor scores each routed response against per-manager expectations.

module tb_user_rom_arbiter;
    import obi_pkg::*;

    localparam int unsigned NumReq = 3;
    localparam int unsigned MaxTxn = 2;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
    } exp_t;

    typedef struct {
        logic [ObiAddrWidth-1:0] addr;
        logic [ObiIdWidth-1:0]   aid;
        int unsigned             due;
    } sub_t;

    logic                  clk = 1'b0;
    logic                  rst;
    obi_req_t [NumReq-1:0] mgr_req;
    obi_rsp_t [NumReq-1:0] mgr_rsp;
    obi_req_t              sbr_req;
    obi_rsp_t              sbr_rsp;
    logic                  busy, spurious;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    int unsigned p_req [NumReq];
    bit          fix_addr [NumReq];
    int unsigned p_gnt, p_spur, stall_min, stall_max;

    int   mptr;
    int   outq [$];
    bit   spur_prev;
    exp_t exp_q [NumReq][$];
    sub_t subq [$];
    bit   hold [NumReq];
    exp_t mon_e;

    always #5 clk = ~clk;

    user_rom_arbiter #(
        .ObiCfg    (ObiDefaultConfig),
        .obi_req_t (obi_req_t),
        .obi_rsp_t (obi_rsp_t),
        .NumReq    (NumReq),
        .MaxTxn    (MaxTxn)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mgr_req_i  (mgr_req),
        .mgr_rsp_o  (mgr_rsp),
        .sbr_req_o  (sbr_req),
        .sbr_rsp_i  (sbr_rsp),
        .busy_o     (busy),
        .spurious_o (spurious)
    );

    function automatic logic [31:0] rom(input logic [31:0] addr);
        return 32'h6F6D6953 ^ (addr * 32'h9E3779B1);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        outq.delete();
        mptr      = 0;
        spur_prev = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            hold[i] = 1'b0;
            exp_q[i].delete();
        end
    endtask

    task automatic drive();
        sub_t s;
        for (int i = 0; i < NumReq; i++) begin
            if (!hold[i]) begin
                mgr_req[i] = '0;
                if ($urandom_range(99) < p_req[i]) begin
                    mgr_req[i].req    = 1'b1;
                    mgr_req[i].a.addr = fix_addr[i] ? '0 : ($urandom_range(0, 255) << 2);
                    mgr_req[i].a.be   = 4'hF;
                    mgr_req[i].a.aid  = 1'($urandom_range(0, 1));
                end
            end
        end
        sbr_rsp     = '0;
        sbr_rsp.gnt = ($urandom_range(99) < p_gnt);
        if (subq.size() != 0 && subq[0].due <= cyc) begin
            s                  = subq.pop_front();
            sbr_rsp.rvalid     = 1'b1;
            sbr_rsp.r.rdata    = rom(s.addr);
            sbr_rsp.r.rid      = s.aid;
        end else if (subq.size() == 0 && $urandom_range(99) < p_spur) begin
            sbr_rsp.rvalid  = 1'b1;
            sbr_rsp.r.rdata = $urandom;
            sbr_rsp.r.rid   = 1'($urandom_range(0, 1));
        end
    endtask

    // Reference: winner = first requester scanning from mptr modulo NumReq; outq holds issuers in order.
    task automatic model_check();
        bit       pop, en, found, hs;
        int       w, j;
        obi_req_t exp_sreq;
        obi_rsp_t exp_rsp;
        exp_t     e;
        pop   = sbr_rsp.rvalid && (outq.size() != 0);
        en    = (outq.size() < MaxTxn) || pop;
        found = 1'b0;
        w     = 0;
        for (int k = 0; k < NumReq; k++) begin
            j = (mptr + k) % NumReq;
            if (!found && mgr_req[j].req) begin
                found = 1'b1;
                w     = j;
            end
        end
        exp_sreq = (en && found) ? mgr_req[w] : '0;
        check("sbr_req", 128'(sbr_req), 128'(exp_sreq));
        check("busy", 128'(busy), 128'(outq.size() != 0));
        check("spurious", 128'(spurious), 128'(spur_prev));
        for (int i = 0; i < NumReq; i++) begin
            exp_rsp     = '0;
            exp_rsp.gnt = en && found && (i == w) && sbr_rsp.gnt;
            if (pop && outq[0] == i) begin
                exp_rsp.rvalid = 1'b1;
                exp_rsp.r      = sbr_rsp.r;
            end
            check($sformatf("mgr_rsp[%0d]", i), 128'(mgr_rsp[i]), 128'(exp_rsp));
        end
        spur_prev = sbr_rsp.rvalid && (outq.size() == 0);
        if (pop) begin
            void'(outq.pop_front());
        end
        hs = en && found && sbr_rsp.gnt;
        if (hs) begin
            outq.push_back(w);
            mptr    = (w + 1) % NumReq;
            e.rdata = rom(mgr_req[w].a.addr);
            e.rid   = mgr_req[w].a.aid;
            exp_q[w].push_back(e);
        end
    endtask

    task automatic observe();
        sub_t s;
        if (sbr_req.req && sbr_rsp.gnt) begin
            s.addr = sbr_req.a.addr;
            s.aid  = sbr_req.a.aid;
            s.due  = cyc + 1 + $urandom_range(stall_min, stall_max);
            subq.push_back(s);
        end
        for (int i = 0; i < NumReq; i++) begin
            hold[i] = mgr_req[i].req && !mgr_rsp[i].gnt;
        end
        cyc++;
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            drive();
            #2;
            model_check();
            observe();
        end
    endtask

    task automatic set_req(input int unsigned p0, input int unsigned p1, input int unsigned p2);
        p_req[0] = p0;
        p_req[1] = p1;
        p_req[2] = p2;
    endtask

    // Reset with requests and a live gnt/rvalid on the inputs: every output must stay quiet.
    task automatic apply_reset(input string tag);
        @(posedge clk);
        #1;
        rst             = 1'b1;
        sbr_rsp         = '0;
        sbr_rsp.gnt     = 1'b1;
        sbr_rsp.rvalid  = 1'b1;
        sbr_rsp.r.rdata = $urandom;
        #1;
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_spurious"}, 128'(spurious), 128'(0));
        check({tag, "_sbr_req"}, 128'(sbr_req.req), 128'(0));
        for (int i = 0; i < NumReq; i++) begin
            check($sformatf("%s_gnt_rvalid[%0d]", tag, i),
                  128'({mgr_rsp[i].gnt, mgr_rsp[i].rvalid}), 128'(0));
        end
        mgr_req = '0;
        sbr_rsp = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NumReq; i++) begin
                if (mgr_rsp[i].rvalid) begin
                    if (exp_q[i].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL resp_unexpected[%0d] (cycle %0d): got rvalid, expected none", i, cyc);
                    end else begin
                        mon_e = exp_q[i].pop_front();
                        check($sformatf("rdata[%0d]", i), 128'(mgr_rsp[i].r.rdata), 128'(mon_e.rdata));
                        check($sformatf("rid[%0d]", i), 128'(mgr_rsp[i].r.rid), 128'(mon_e.rid));
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        mgr_req = '0;
        sbr_rsp = '0;
        for (int i = 0; i < NumReq; i++) begin
            mgr_req[i].req = 1'b1;
            fix_addr[i]    = 1'b0;
        end
        set_req(0, 0, 0);
        p_gnt     = 100;
        p_spur    = 0;
        stall_min = 0;
        stall_max = 0;
        model_reset();
        repeat (2) @(posedge clk);
        apply_reset("por");

        // Single manager reading ROM address 0.
        fix_addr[0] = 1'b1;
        set_req(100, 0, 0);
        step(1);
        fix_addr[0] = 1'b0;
        set_req(0, 0, 0);
        step(3);

        // Two managers contending with a one-cycle ROM.
        set_req(100, 100, 0);
        step(6);
        set_req(0, 0, 0);
        step(3);

        // Full routing FIFO with a subordinate stalling rvalid.
        stall_min = 3;
        stall_max = 3;
        set_req(100, 100, 0);
        step(10);
        set_req(0, 0, 0);
        step(8);

        // Pointer wrap: grant manager 1 alone, then 0 and 1 together.
        stall_min = 0;
        stall_max = 0;
        set_req(0, 100, 0);
        step(1);
        set_req(100, 100, 0);
        step(2);
        set_req(0, 0, 0);
        step(3);

        // Spurious response with nothing outstanding.
        p_spur = 100;
        step(1);
        p_spur = 0;
        step(3);

        // Reset with two transactions in flight; the stale responses arrive as spurious.
        stall_min = 3;
        stall_max = 3;
        set_req(100, 100, 0);
        step(2);
        apply_reset("mid");
        set_req(0, 0, 0);
        step(8);
        set_req(100, 100, 100);
        step(3);
        set_req(0, 0, 0);
        step(8);

        // Randomised traffic.
        stall_min = 0;
        stall_max = 3;
        p_gnt     = 70;
        p_spur    = 3;
        set_req(50, 50, 50);
        step(500);

        // Drain.
        set_req(0, 0, 0);
        p_gnt     = 100;
        p_spur    = 0;
        stall_max = 0;
        for (int n = 0; n < 50 && (subq.size() != 0 || outq.size() != 0); n++) begin
            step(1);
        end
        step(2);
        check("drain_busy", 128'(busy), 128'(0));
        for (int i = 0; i < NumReq; i++) begin
            check($sformatf("drain_pending[%0d]", i), 128'(exp_q[i].size()), 128'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
